// File: rtl/cmp_sched.sv
// Round-robin scheduler sharing one branch/compare unit between branch and SLT requesters.
// Optional event counters are enabled by defining CMP_SCHED_STATS_EN.
module cmp_sched #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned RESET_PRIO = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_req,
  input  logic [2:0]       br_funct3,
  input  logic [WIDTH-1:0] br_a,
  input  logic [WIDTH-1:0] br_b,
  output logic             br_gnt,
  output logic             br_resp_valid,
  input  logic             br_resp_ready,
  output logic             br_taken,
  output logic             br_err,
  input  logic             slt_req,
  input  logic             slt_unsigned,
  input  logic [WIDTH-1:0] slt_a,
  input  logic [WIDTH-1:0] slt_b,
  output logic             slt_gnt,
  output logic             slt_resp_valid,
  input  logic             slt_resp_ready,
  output logic             slt_result,
  output logic [2:0]       cmpop,
  output logic [WIDTH-1:0] cmp_rs1,
  output logic [WIDTH-1:0] cmp_rhs,
  input  logic             br_en
`ifdef CMP_SCHED_STATS_EN
  ,
  output logic [31:0]      stat_br_cnt,
  output logic [31:0]      stat_slt_cnt,
  output logic [31:0]      stat_conflict_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e           state_q, state_d;
  logic             prio_q, prio_d;    // 0: branch wins a tie, 1: slt wins a tie
  logic             owner_q, owner_d;  // 0: branch, 1: slt
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] rs1_q, rs1_d;
  logic [WIDTH-1:0] rhs_q, rhs_d;
  logic             err_q, err_d;
  logic             res_q, res_d;
  logic             br_win, slt_win;

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    op_d    = op_q;
    rs1_d   = rs1_q;
    rhs_d   = rhs_q;
    err_d   = err_q;
    res_d   = res_q;
    br_win  = 1'b0;
    slt_win = 1'b0;
    case (state_q)
      StIdle: begin
        br_win  = br_req & (~slt_req | ~prio_q);
        slt_win = slt_req & (~br_req | prio_q);
        if (br_win) begin
          owner_d = 1'b0;
          op_d    = br_funct3;
          rs1_d   = br_a;
          rhs_d   = br_b;
          err_d   = (br_funct3[2:1] == 2'b01);
          prio_d  = 1'b1;
          state_d = StIssue;
        end else if (slt_win) begin
          owner_d = 1'b1;
          op_d    = {1'b1, slt_unsigned, 1'b0};
          rs1_d   = slt_a;
          rhs_d   = slt_b;
          err_d   = 1'b0;
          prio_d  = 1'b0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        // Illegal funct3 still occupies the comparator slot but never reports taken.
        res_d   = br_en & ~err_q;
        state_d = StResp;
      end
      StResp: begin
        if (owner_q ? slt_resp_ready : br_resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      prio_q  <= (RESET_PRIO != 0);
      owner_q <= 1'b0;
      op_q    <= 3'b000;
      rs1_q   <= '0;
      rhs_q   <= '0;
      err_q   <= 1'b0;
      res_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      rs1_q   <= rs1_d;
      rhs_q   <= rhs_d;
      err_q   <= err_d;
      res_q   <= res_d;
    end
  end

  assign br_gnt         = br_win;
  assign slt_gnt        = slt_win;
  assign br_resp_valid  = (state_q == StResp) & ~owner_q;
  assign slt_resp_valid = (state_q == StResp) & owner_q;
  assign br_taken       = br_resp_valid & res_q;
  assign br_err         = br_resp_valid & err_q;
  assign slt_result     = slt_resp_valid & res_q;
  assign cmpop          = op_q;
  assign cmp_rs1        = rs1_q;
  assign cmp_rhs        = rhs_q;

`ifdef CMP_SCHED_STATS_EN
  logic [31:0] br_cnt_q, slt_cnt_q, conflict_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_q       <= '0;
      slt_cnt_q      <= '0;
      conflict_cnt_q <= '0;
    end else begin
      if (br_win)  br_cnt_q  <= br_cnt_q + 32'd1;
      if (slt_win) slt_cnt_q <= slt_cnt_q + 32'd1;
      if ((state_q == StIdle) && br_req && slt_req) begin
        conflict_cnt_q <= conflict_cnt_q + 32'd1;
      end
    end
  end

  assign stat_br_cnt       = br_cnt_q;
  assign stat_slt_cnt      = slt_cnt_q;
  assign stat_conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_cmp_sched.sv
// Directed testbench for cmp_sched; includes a behavioural model of the comparator it drives.
module tb_cmp_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        br_req = 1'b0;
  logic [2:0]  br_funct3 = 3'b000;
  logic [31:0] br_a = '0, br_b = '0;
  logic        br_gnt, br_resp_valid, br_taken, br_err;
  logic        br_resp_ready = 1'b1;
  logic        slt_req = 1'b0;
  logic        slt_unsigned = 1'b0;
  logic [31:0] slt_a = '0, slt_b = '0;
  logic        slt_gnt, slt_resp_valid, slt_result;
  logic        slt_resp_ready = 1'b1;
  logic [2:0]  cmpop;
  logic [31:0] cmp_rs1, cmp_rhs;
  logic        br_en;
  logic        lt_s, lt_u, eq;
`ifdef CMP_SCHED_STATS_EN
  logic [31:0] stat_br_cnt, stat_slt_cnt, stat_conflict_cnt;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  // Comparator: bit0 inverts, bit2 selects less-than, bit1 selects unsigned.
  assign lt_s  = $signed(cmp_rs1) < $signed(cmp_rhs);
  assign lt_u  = cmp_rs1 < cmp_rhs;
  assign eq    = cmp_rs1 == cmp_rhs;
  assign br_en = (cmpop[2] ? (cmpop[1] ? lt_u : lt_s) : eq) ^ cmpop[0];

  cmp_sched #(.WIDTH(32), .RESET_PRIO(0)) dut (
    .clk            (clk),
    .rst            (rst),
    .br_req         (br_req),
    .br_funct3      (br_funct3),
    .br_a           (br_a),
    .br_b           (br_b),
    .br_gnt         (br_gnt),
    .br_resp_valid  (br_resp_valid),
    .br_resp_ready  (br_resp_ready),
    .br_taken       (br_taken),
    .br_err         (br_err),
    .slt_req        (slt_req),
    .slt_unsigned   (slt_unsigned),
    .slt_a          (slt_a),
    .slt_b          (slt_b),
    .slt_gnt        (slt_gnt),
    .slt_resp_valid (slt_resp_valid),
    .slt_resp_ready (slt_resp_ready),
    .slt_result     (slt_result),
    .cmpop          (cmpop),
    .cmp_rs1        (cmp_rs1),
    .cmp_rhs        (cmp_rhs),
    .br_en          (br_en)
`ifdef CMP_SCHED_STATS_EN
    ,
    .stat_br_cnt       (stat_br_cnt),
    .stat_slt_cnt      (stat_slt_cnt),
    .stat_conflict_cnt (stat_conflict_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    br_req  = 1'b0;
    slt_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge with the DUT idle and br_resp_ready high.
  task automatic run_br(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic exp_taken, input logic exp_err);
    br_req = 1'b1; br_funct3 = f3; br_a = a; br_b = b;
    #1;
    check("br_gnt", 32'(br_gnt), 1);
    check("br_slt_gnt", 32'(slt_gnt), 0);
    @(negedge clk);
    br_req = 1'b0;
    #1;
    check("br_cmpop", 32'(cmpop), 32'(f3));
    check("br_rs1", cmp_rs1, a);
    check("br_rhs", cmp_rhs, b);
    check("br_valid_issue", 32'(br_resp_valid), 0);
    @(negedge clk);
    #1;
    check("br_valid", 32'(br_resp_valid), 1);
    check("br_taken", 32'(br_taken), 32'(exp_taken));
    check("br_err", 32'(br_err), 32'(exp_err));
    check("br_slt_valid", 32'(slt_resp_valid), 0);
    @(negedge clk);
  endtask

  task automatic run_slt(input logic uns, input logic [31:0] a, input logic [31:0] b,
                         input logic exp_res);
    slt_req = 1'b1; slt_unsigned = uns; slt_a = a; slt_b = b;
    #1;
    check("slt_gnt", 32'(slt_gnt), 1);
    @(negedge clk);
    slt_req = 1'b0;
    #1;
    check("slt_cmpop", 32'(cmpop), 32'({1'b1, uns, 1'b0}));
    check("slt_rs1", cmp_rs1, a);
    @(negedge clk);
    #1;
    check("slt_valid", 32'(slt_resp_valid), 1);
    check("slt_result", 32'(slt_result), 32'(exp_res));
    check("slt_br_valid", 32'(br_resp_valid), 0);
    @(negedge clk);
  endtask

  initial begin
    do_reset();
    #1;
    check("rst_br_valid", 32'(br_resp_valid), 0);
    check("rst_slt_valid", 32'(slt_resp_valid), 0);
    check("rst_br_gnt", 32'(br_gnt), 0);
    check("rst_cmpop", 32'(cmpop), 0);
    check("rst_rs1", cmp_rs1, 0);
    check("rst_rhs", cmp_rhs, 0);
    check("rst_taken", 32'(br_taken), 0);
    check("rst_err", 32'(br_err), 0);
    check("rst_slt_result", 32'(slt_result), 0);
    @(negedge clk);

    run_br(3'b000, 32'd5, 32'd5, 1'b1, 1'b0);                 // beq equal
    run_slt(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b1);                // slt: -1 < 1
    run_slt(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0);                // sltu: max !< 1
    run_br(3'b111, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);         // bgeu
    run_br(3'b100, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);         // blt
    run_br(3'b001, 32'd3, 32'd3, 1'b0, 1'b0);                 // bne equal
    run_br(3'b010, 32'd0, 32'd0, 1'b0, 1'b1);                 // illegal
    run_br(3'b011, 32'd7, 32'd9, 1'b0, 1'b1);                 // illegal

    // Continuous contention: grants alternate every three cycles.
    do_reset();
    br_req = 1'b1; br_funct3 = 3'b000; br_a = 32'd1; br_b = 32'd1;
    slt_req = 1'b1; slt_unsigned = 1'b0; slt_a = 32'd1; slt_b = 32'd2;
    for (int c = 0; c < 12; c++) begin
      #1;
      check($sformatf("cont_br_gnt_c%0d", c), 32'(br_gnt), 32'(c == 0 || c == 6));
      check($sformatf("cont_slt_gnt_c%0d", c), 32'(slt_gnt), 32'(c == 3 || c == 9));
      check($sformatf("cont_br_valid_c%0d", c), 32'(br_resp_valid), 32'(c == 2 || c == 8));
      check($sformatf("cont_slt_valid_c%0d", c), 32'(slt_resp_valid),
            32'(c == 5 || c == 11));
      @(negedge clk);
    end
    br_req = 1'b0; slt_req = 1'b0;
`ifdef CMP_SCHED_STATS_EN
    #1;
    check("stat_br", stat_br_cnt, 2);
    check("stat_slt", stat_slt_cnt, 2);
    check("stat_conflict", stat_conflict_cnt, 4);
`endif
    @(negedge clk);

    // Backpressure on the branch response while slt waits.
    br_req = 1'b1; br_funct3 = 3'b100; br_a = 32'hFFFF_FFFF; br_b = 32'd1;
    br_resp_ready = 1'b0;
    #1;
    check("bp_br_gnt", 32'(br_gnt), 1);
    @(negedge clk);
    br_req = 1'b0; slt_req = 1'b1; slt_unsigned = 1'b0; slt_a = 32'd1; slt_b = 32'd2;
    #1;
    check("bp_slt_gnt_issue", 32'(slt_gnt), 0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("bp_valid_%0d", i), 32'(br_resp_valid), 1);
      check($sformatf("bp_taken_%0d", i), 32'(br_taken), 1);
      check($sformatf("bp_slt_gnt_%0d", i), 32'(slt_gnt), 0);
      @(negedge clk);
    end
    br_resp_ready = 1'b1;
    #1;
    check("bp_accept_valid", 32'(br_resp_valid), 1);
    check("bp_accept_slt_gnt", 32'(slt_gnt), 0);
    @(negedge clk);
    #1;
    check("bp_slt_gnt_after", 32'(slt_gnt), 1);
    check("bp_br_valid_after", 32'(br_resp_valid), 0);
    @(negedge clk);
    slt_req = 1'b0;
    @(negedge clk);
    #1;
    check("bp_slt_valid", 32'(slt_resp_valid), 1);
    check("bp_slt_result", 32'(slt_result), 1);
    @(negedge clk);

    // Reset while a branch response is pending.
    br_req = 1'b1; br_funct3 = 3'b000; br_a = 32'd1; br_b = 32'd2; br_resp_ready = 1'b0;
    #1;
    check("rr_br_gnt", 32'(br_gnt), 1);
    @(negedge clk);
    br_req = 1'b0;
    @(negedge clk);
    #1;
    check("rr_valid_before", 32'(br_resp_valid), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rr_br_valid", 32'(br_resp_valid), 0);
    check("rr_slt_valid", 32'(slt_resp_valid), 0);
    check("rr_cmpop", 32'(cmpop), 0);
`ifdef CMP_SCHED_STATS_EN
    check("rr_stat_br", stat_br_cnt, 0);
    check("rr_stat_slt", stat_slt_cnt, 0);
    check("rr_stat_conflict", stat_conflict_cnt, 0);
`endif
    br_req = 1'b1; slt_req = 1'b1; br_resp_ready = 1'b1;
    #1;
    check("rr_prio_br_gnt", 32'(br_gnt), 1);
    check("rr_prio_slt_gnt", 32'(slt_gnt), 0);
    @(negedge clk);
    br_req = 1'b0; slt_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cmp_sched.md
Name: cmp_sched

Overview:
Scheduler that shares the single branch/compare unit (cmp) between two requesters: the branch-resolution path and the SLT/SLTI/SLTU(I) writeback path.
- Arbitrates requests round-robin.
- Latches operands and drives cmp's cmpop/rs1_o/cmpmux_o.
- Captures br_en and returns the result over a valid/ready response handshake.
- Sits between decode/execute control and cmp in the multicycle datapath.

Parameters:
WIDTH, 32, operand width driven to comparator
RESET_PRIO, 0, priority holder after reset (0 = branch requester, 1 = slt requester)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
br_req  in  1  branch requester wants a compare; held until br_gnt
br_funct3  in  3  branch funct3 (000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu)
br_a  in  WIDTH  rs1 value
br_b  in  WIDTH  rs2 value
br_gnt  out  1  one-cycle pulse: branch request accepted, operands sampled this cycle
br_resp_valid  out  1  branch result valid
br_resp_ready  in  1  branch consumer accepts result
br_taken  out  1  compare result for branch
br_err  out  1  illegal funct3 (010/011); valid with br_resp_valid
slt_req  in  1  slt requester wants a compare; held until slt_gnt
slt_unsigned  in  1  1 = sltu (cmpop 110), 0 = slt (cmpop 100)
slt_a  in  WIDTH  rs1 value
slt_b  in  WIDTH  rs2 or immediate
slt_gnt  out  1  one-cycle accept pulse
slt_resp_valid  out  1  slt result valid
slt_resp_ready  in  1  slt consumer accepts result
slt_result  out  1  1 if less-than
cmpop  out  3  to comparator
cmp_rs1  out  WIDTH  to comparator rs1_o
cmp_rhs  out  WIDTH  to comparator cmpmux_o
br_en  in  1  comparator result, combinational from cmpop/cmp_rs1/cmp_rhs

Behaviour:
- Reset (rst=1 at posedge):
  - State IDLE; priority pointer = RESET_PRIO.
  - All gnt/resp_valid/err/result outputs = 0; cmpop = 000; cmp_rs1 = cmp_rhs = 0.
  - Reset mid-transaction drops the transaction silently. No response is issued.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - Grant rules:
    - One req high: grant it.
    - Both high: grant the requester named by the priority pointer.
    - No req: stay IDLE.
  - On grant (cycle N):
    - gnt pulses combinationally in cycle N.
    - Operands, op and owner latched at posedge ending N.
    - Pointer moves to the other requester.
    - Next state ISSUE.
- ISSUE (cycle N+1):
  - Latched operands and cmpop driven to comparator.
  - br_en captured at posedge ending N+1.
  - Next state RESP.
- RESP (N+2 onward):
  - Owner's resp_valid = 1 with a stable result; the non-owner's resp_valid = 0.
  - Hold until owner's resp_ready = 1. On that posedge, go to IDLE.
  - No new grant in the same cycle; the minimum request-to-request spacing is 3 cycles.
- Op mapping:
  - Branch: cmpop = br_funct3.
  - slt: cmpop = {1'b1, slt_unsigned, 1'b0}. Invert bit is never set.
- Illegal branch funct3 010/011: still sequenced through ISSUE; br_taken = 0, br_err = 1 in RESP.
- cmpop/cmp_rs1/cmp_rhs hold last latched values in IDLE and RESP; values are only meaningful in ISSUE.
- gnt never asserts outside IDLE. Requests arriving in ISSUE/RESP wait (req held).
- A requester dropping req before gnt is allowed; no side effects.
- Fairness: under continuous contention, grants strictly alternate.

Optional Feature:
CMP_SCHED_STATS_EN
- Defined: adds outputs stat_br_cnt[31:0], stat_slt_cnt[31:0] and stat_conflict_cnt[31:0].
  - stat_br_cnt / stat_slt_cnt increment on each respective gnt.
  - stat_conflict_cnt increments each IDLE cycle where both req are high.
  - All zeroed on rst; wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset then single branch: br_req=1, funct3=000, a=b=5 at cycle 0 -> br_gnt cycle 0, cmpop=000 cycle 1, br_resp_valid cycle 2 with br_taken=1, br_err=0; resp_ready=1 -> IDLE cycle 3.
- Signed vs unsigned: slt a=32'hFFFF_FFFF, b=1 -> slt_result=1 with slt_unsigned=0, 0 with slt_unsigned=1; bgeu (111) same operands -> br_taken=1.
- Contention: both req held high continuously, RESET_PRIO=0 -> grants br, slt, br, slt at cycles 0, 3, 6, 9 (resp_ready tied 1).
- Backpressure: br_resp_ready=0 for 5 cycles -> br_resp_valid and br_taken stable, slt_req pending gets no gnt until cycle after acceptance.
- Illegal funct3=010, a=b=0 -> br_resp_valid with br_taken=0, br_err=1.
- rst asserted during RESP -> next cycle all resp_valid=0, state IDLE, pointer = RESET_PRIO; with CMP_SCHED_STATS_EN, counters read 0.
